// File: rtl/multi_seq_nxm.sv
// Sequential shift-and-add multiplier: scans the multiplier LSB first, one bit per clock.
// Define MULTI_SIGNED_EN for two's complement operands (final partial product subtracted).
module multi_seq_nxm #(
   parameter int unsigned A_W = 4,
   parameter int unsigned B_W = 4
) (
   input  logic               clk,
   input  logic               clr,
   input  logic               start,
   input  logic [A_W-1:0]     a,
   input  logic [B_W-1:0]     b,
   output logic               busy,
   output logic               done,
   output logic [A_W+B_W-1:0] p
);

   localparam int unsigned P_W = A_W + B_W;
   localparam int unsigned C_W = (A_W > 1) ? $clog2(A_W) : 1;
   localparam logic [C_W-1:0] LAST = C_W'(A_W - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_nxt;
   logic [A_W-1:0]   a_q, a_nxt;
   logic [P_W-1:0]   m_q, m_nxt;
   logic [P_W-1:0]   acc_q, acc_nxt;
   logic [C_W-1:0]   cnt_q, cnt_nxt;
   logic [P_W-1:0]   p_nxt;
   logic             done_nxt;
   logic             busy_nxt;
   logic [P_W-1:0]   b_ext_c;
   logic [P_W-1:0]   addend;
   logic [P_W-1:0]   acc_sum;

   // Multiplicand widened to the product width
`ifdef MULTI_SIGNED_EN
   assign b_ext_c = {{A_W{b[B_W-1]}}, b};
`else
   assign b_ext_c = {{A_W{1'b0}}, b};
`endif

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) state_q <= S_IDLE;
      else      state_q <= state_nxt;
   end

   always_comb begin
      state_nxt = state_q;
      a_nxt     = a_q;
      m_nxt     = m_q;
      acc_nxt   = acc_q;
      cnt_nxt   = cnt_q;
      p_nxt     = p;
      done_nxt  = 1'b0;
      addend    = '0;
      acc_sum   = acc_q;

      case (state_q)
         S_RUN: begin
            addend = a_q[0] ? m_q : '0;
`ifdef MULTI_SIGNED_EN
            // Sign bit of the multiplier carries weight -2^(A_W-1)
            acc_sum = (cnt_q == LAST) ? (acc_q - addend) : (acc_q + addend);
`else
            acc_sum = acc_q + addend;
`endif
            acc_nxt = acc_sum;
            a_nxt   = a_q >> 1;
            m_nxt   = m_q << 1;
            cnt_nxt = cnt_q + C_W'(1);
            if (cnt_q == LAST) begin
               p_nxt     = acc_sum;
               done_nxt  = 1'b1;
               state_nxt = S_DONE;
            end
         end
         default: begin
            if (start) begin
               a_nxt     = a;
               m_nxt     = b_ext_c;
               acc_nxt   = '0;
               cnt_nxt   = '0;
               state_nxt = S_RUN;
            end else if (state_q == S_DONE) begin
               state_nxt = S_IDLE;
            end
         end
      endcase

      busy_nxt = (state_nxt == S_RUN);
   end

   // Datapath and registered outputs
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         a_q   <= '0;
         m_q   <= '0;
         acc_q <= '0;
         cnt_q <= '0;
         p     <= '0;
         done  <= 1'b0;
         busy  <= 1'b0;
      end else begin
         a_q   <= a_nxt;
         m_q   <= m_nxt;
         acc_q <= acc_nxt;
         cnt_q <= cnt_nxt;
         p     <= p_nxt;
         done  <= done_nxt;
         busy  <= busy_nxt;
      end
   end

endmodule

// File: tb/tb_multi_seq_nxm.sv
// Scoreboard bench for multi_seq_nxm: a 4x4 lane (directed, held-start, reset abort)
// and an 8x12 lane (random operands), each with its own reference model and monitor.
module tb_multi_seq_nxm;

   logic        clk = 1'b0;
   logic        clr;
   logic        start_s [2];
   logic [31:0] a_s     [2];
   logic [31:0] b_s     [2];

   int unsigned vectors = 0;
   int unsigned errs    = 0;

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : lane
      localparam int unsigned AW = (g == 0) ? 4 : 8;
      localparam int unsigned BW = (g == 0) ? 4 : 12;
      localparam int unsigned PW = AW + BW;

      typedef struct packed {
         logic [PW-1:0] p;
         int unsigned   due;
      } exp_t;

      logic          busy, done;
      logic [PW-1:0] p;
      exp_t          q [$];
      logic [PW-1:0] p_hold;
      logic          run;
      int unsigned   rcnt;
      int unsigned   lcyc = 0;

      multi_seq_nxm #(.A_W(AW), .B_W(BW)) dut (
         .clk   (clk),
         .clr   (clr),
         .start (start_s[g]),
         .a     (a_s[g][AW-1:0]),
         .b     (b_s[g][BW-1:0]),
         .busy  (busy),
         .done  (done),
         .p     (p)
      );

      function automatic logic [PW-1:0] ref_prod(input logic [31:0] av, input logic [31:0] bv);
`ifdef MULTI_SIGNED_EN
         logic signed [PW-1:0] sa, sb;
         sa = {{BW{av[AW-1]}}, av[AW-1:0]};
         sb = {{AW{bv[BW-1]}}, bv[BW-1:0]};
         return PW'(sa * sb);
`else
         logic [PW-1:0] ua, ub;
         ua = {{BW{1'b0}}, av[AW-1:0]};
         ub = {{AW{1'b0}}, bv[BW-1:0]};
         return PW'(ua * ub);
`endif
      endfunction

      // Handshake model: accept when not iterating, result due AW edges later
      always @(posedge clk or negedge clr) begin
         if (!clr) begin
            q.delete();
            run  = 1'b0;
            rcnt = 0;
         end else begin
            lcyc++;
            if (!run && start_s[g]) begin
               q.push_back('{p: ref_prod(a_s[g], b_s[g]), due: lcyc + AW});
               run  = 1'b1;
               rcnt = 0;
            end else if (run) begin
               rcnt++;
               if (rcnt == AW) run = 1'b0;
            end
         end
      end

      always @(negedge clk) begin
         logic due_now;
         if (!clr) begin
            p_hold = '0;
         end else begin
            check($sformatf("busy%0d", g), 64'(busy), 64'(run));
            due_now = (q.size() > 0) && (q[0].due == lcyc);
            if (done || due_now) begin
               check($sformatf("done%0d", g), 64'(done), 64'(due_now));
               if (due_now) begin
                  check($sformatf("p%0d", g), 64'(p), 64'(q[0].p));
                  p_hold = q[0].p;
                  void'(q.pop_front());
               end
            end else begin
               check($sformatf("p_hold%0d", g), 64'(p), 64'(p_hold));
            end
         end
      end
   end

   // One accepted start on lane l, operands scrambled afterwards, then wait_n edges
   task automatic op(input int l, input logic [31:0] av, input logic [31:0] bv, input int wait_n);
      start_s[l] = 1'b1;
      a_s[l]     = av;
      b_s[l]     = bv;
      @(posedge clk); #1;
      start_s[l] = 1'b0;
      a_s[l]     = $urandom;
      b_s[l]     = $urandom;
      repeat (wait_n) @(posedge clk);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      clr = 1'b0;
      for (int i = 0; i < 2; i++) begin
         start_s[i] = 1'b0;
         a_s[i]     = '0;
         b_s[i]     = '0;
      end
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 64'(lane[0].busy), 64'(0));
      check("rst_done", 64'(lane[0].done), 64'(0));
      check("rst_p",    64'(lane[0].p),    64'(0));
      check("rst_p1",   64'(lane[1].p),    64'(0));
      clr = 1'b1;

      // Directed 4x4 vectors, one-cycle starts, alternating IDLE and DONE restarts
      op(0, 32'hF, 32'hF, 5);
      op(0, 32'h8, 32'h9, 4);
      op(0, 32'h0, 32'hF, 5);
      op(0, 32'h8, 32'h7, 4);
      op(0, 32'h8, 32'h8, 5);
      op(0, 32'hF, 32'hF, 5);

      // start held high with operands changing every cycle
      start_s[0] = 1'b1;
      for (int i = 0; i < 15; i++) begin
         a_s[0] = $urandom;
         b_s[0] = $urandom;
         @(posedge clk); #1;
      end
      start_s[0] = 1'b0;
      repeat (6) @(posedge clk);
      #1;

      // Reset abort at RUN edge 2
      start_s[0] = 1'b1;
      a_s[0]     = 32'hB;
      b_s[0]     = 32'hD;
      @(posedge clk); #1;
      start_s[0] = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      clr = 1'b0;
      #1;
      check("abort_busy", 64'(lane[0].busy), 64'(0));
      check("abort_done", 64'(lane[0].done), 64'(0));
      check("abort_p",    64'(lane[0].p),    64'(0));
      repeat (2) @(posedge clk);
      #1;
      clr = 1'b1;
      op(0, 32'hB, 32'hD, 5);

      for (int i = 0; i < 200; i++)
         op(0, $urandom, $urandom, 4 + int'($urandom_range(0, 2)));

      for (int i = 0; i < 1000; i++)
         op(1, $urandom, $urandom, 8 + int'($urandom_range(0, 2)));

      repeat (12) @(posedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
